// File: rtl/jacobi_pkg.sv
// Shared types and helpers for the Jacobi sweep controller and its off-diagonal scanner.
package jacobi_pkg;

  localparam int WIDTH     = 16;
  localparam int FRAC_BITS = 13;
  localparam int N_STOCKS  = 4;
  localparam int IDX_W     = $clog2(N_STOCKS);
  localparam int PAIR_W    = $clog2(WIDTH);

  localparam logic [WIDTH-1:0] ONE = WIDTH'(1) << FRAC_BITS;

  typedef logic [WIDTH-1:0] elem_t;
  typedef elem_t [N_STOCKS-1:0][N_STOCKS-1:0] mat_t;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    ISSUE,
    WAIT,
    CHECK,
    DONE
  } sweep_state_t;

  // Magnitude of a signed element; the most negative code saturates to max positive.
  function automatic elem_t abs_sat(input elem_t x);
    if (x == {1'b1, {(WIDTH-1){1'b0}}}) return {1'b0, {(WIDTH-1){1'b1}}};
    else if (x[WIDTH-1])                return -x;
    else                                return x;
  endfunction

  function automatic mat_t identity();
    mat_t m;
    m = '0;
    for (int k = 0; k < N_STOCKS; k++) m[k][k] = ONE;
    return m;
  endfunction

endpackage

// File: rtl/offdiag_max_scan.sv
// Sequential max-|a| scanner: walks all N*N entries one per cycle, ignoring the diagonal.
module offdiag_max_scan
  import jacobi_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  scan_start,
  input  mat_t  mat,
  output logic  scan_done,
  output elem_t max_abs
);

  localparam logic [IDX_W-1:0] LAST = IDX_W'(N_STOCKS - 1);

  logic             active;
  logic [IDX_W-1:0] row, col;
  elem_t            cur;

  assign cur = abs_sat(mat[row][col]);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active    <= 1'b0;
      row       <= '0;
      col       <= '0;
      max_abs   <= '0;
      scan_done <= 1'b0;
    end else begin
      scan_done <= 1'b0;
      if (scan_start) begin
        active  <= 1'b1;
        row     <= '0;
        col     <= '0;
        max_abs <= '0;
      end else if (active) begin
        if (row != col && cur > max_abs) max_abs <= cur;
        if (col == LAST) begin
          col <= '0;
          if (row == LAST) begin
            active    <= 1'b0;
            scan_done <= 1'b1;
          end else begin
            row <= row + 1'b1;
          end
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/jacobi_sweep_ctrl.sv
// Cyclic Jacobi sweep controller driving an external rotation engine.
// Optional JACOBI_SKIP_SMALL_EN: pairs whose pivot is already within TOL are skipped without a request.
module jacobi_sweep_ctrl
  import jacobi_pkg::*;
#(
  parameter int MAX_SWEEPS = 8,
  parameter int TOL        = 16
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            start,
  input  mat_t                            a_in,
  output logic                            busy,
  output logic                            done,
  output logic                            converged,
  output logic [$clog2(MAX_SWEEPS+1)-1:0] sweeps,
  output mat_t                            a_out,
  output mat_t                            v_out,
  output logic                            rot_valid,
  output logic [PAIR_W-1:0]               rot_i,
  output logic [PAIR_W-1:0]               rot_j,
  output mat_t                            rot_diag,
  output mat_t                            rot_q,
  input  logic                            rot_done,
  input  mat_t                            rot_diag_res,
  input  mat_t                            rot_q_res
);

  localparam int               SW_W   = $clog2(MAX_SWEEPS + 1);
  localparam logic [IDX_W-1:0] LAST_J = IDX_W'(N_STOCKS - 1);
  localparam logic [IDX_W-1:0] LAST_I = IDX_W'(N_STOCKS - 2);
  localparam elem_t            TOL_E  = WIDTH'(TOL);

  sweep_state_t     state, state_d;
  mat_t             a_q, v_q;
  logic [IDX_W-1:0] pi, pj;
  logic             last_pair, skip;
  logic             accept, take_res, advance, set_first, end_sweep, finish, conv_d;
  logic             scan_done;
  elem_t            max_abs;

  assign last_pair = (pi == LAST_I) && (pj == LAST_J);

`ifdef JACOBI_SKIP_SMALL_EN
  assign skip = (abs_sat(a_q[pi][pj]) <= TOL_E);
`else
  assign skip = 1'b0;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_d;
  end

  // NOTE: every signal driven here gets a default first, so no path can infer a latch.
  always_comb begin
    state_d   = state;
    accept    = 1'b0;
    take_res  = 1'b0;
    advance   = 1'b0;
    set_first = 1'b0;
    end_sweep = 1'b0;
    finish    = 1'b0;
    conv_d    = 1'b0;
    rot_valid = 1'b0;
    unique case (state)
      IDLE: if (start) begin
        accept  = 1'b1;
        state_d = LOAD;
      end
      LOAD: begin
        set_first = 1'b1;
        state_d   = ISSUE;
      end
      ISSUE: begin
        if (skip) begin
          if (last_pair) begin
            end_sweep = 1'b1;
            state_d   = CHECK;
          end else begin
            advance = 1'b1;
          end
        end else begin
          rot_valid = 1'b1;
          state_d   = WAIT;
        end
      end
      WAIT: if (rot_done) begin
        take_res = 1'b1;
        if (last_pair) begin
          end_sweep = 1'b1;
          state_d   = CHECK;
        end else begin
          advance = 1'b1;
          state_d = ISSUE;
        end
      end
      CHECK: if (scan_done) begin
        if (max_abs <= TOL_E) begin
          conv_d  = 1'b1;
          finish  = 1'b1;
          state_d = DONE;
        end else if (sweeps == SW_W'(MAX_SWEEPS)) begin
          finish  = 1'b1;
          state_d = DONE;
        end else begin
          set_first = 1'b1;
          state_d   = ISSUE;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: the matrix registers are reset too, because they are visible on outputs with defined reset values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      v_q       <= '0;
      pi        <= '0;
      pj        <= '0;
      sweeps    <= '0;
      converged <= 1'b0;
      a_out     <= '0;
      v_out     <= '0;
    end else begin
      if (accept) begin
        a_q       <= a_in;
        v_q       <= identity();
        sweeps    <= '0;
        converged <= 1'b0;
      end
      if (take_res) begin
        a_q <= rot_diag_res;
        v_q <= rot_q_res;
      end
      if (set_first) begin
        pi <= '0;
        pj <= IDX_W'(1);
      end else if (advance) begin
        if (pj == LAST_J) begin
          pi <= pi + 1'b1;
          pj <= pi + IDX_W'(2);
        end else begin
          pj <= pj + 1'b1;
        end
      end
      if (end_sweep) sweeps <= sweeps + 1'b1;
      if (finish) begin
        a_out     <= a_q;
        v_out     <= v_q;
        converged <= conv_d;
      end
    end
  end

  offdiag_max_scan u_scan (
    .clk        (clk),
    .rst_n      (rst_n),
    .scan_start (end_sweep),
    .mat        (a_q),
    .scan_done  (scan_done),
    .max_abs    (max_abs)
  );

  assign busy     = (state != IDLE);
  assign done     = (state == DONE);
  assign rot_i    = PAIR_W'(pi);
  assign rot_j    = PAIR_W'(pj);
  assign rot_diag = a_q;
  assign rot_q    = v_q;

endmodule

// File: tb/tb_jacobi_sweep_ctrl.sv
// Scoreboard bench for jacobi_sweep_ctrl with a behavioural engine and sweep reference model.
module tb_jacobi_sweep_ctrl;
  import jacobi_pkg::*;

  localparam int N    = N_STOCKS;
  localparam int MAXS = 8;
  localparam int TOLV = 16;
`ifdef JACOBI_SKIP_SMALL_EN
  localparam bit SKIP = 1'b1;
`else
  localparam bit SKIP = 1'b0;
`endif

  typedef struct { int i; int j; mat_t a; mat_t v; } req_t;
  typedef struct { mat_t a; mat_t v; bit conv; int sw; } res_t;

  logic              clk = 1'b0;
  logic              rst_n, start, rot_done;
  mat_t              a_in, rot_diag_res, rot_q_res;
  logic              busy, done, converged, rot_valid;
  logic [3:0]        sweeps;
  logic [PAIR_W-1:0] rot_i, rot_j;
  mat_t              a_out, v_out, rot_diag, rot_q;

  int   vectors = 0;
  int   errors  = 0;
  req_t req_q[$];
  res_t done_q[$];

  int   eng_mode, eng_lat, req_cnt;
  bit   stray_en;

  always #5 clk = ~clk;

  jacobi_sweep_ctrl #(.MAX_SWEEPS(MAXS), .TOL(TOLV)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .a_in         (a_in),
    .busy         (busy),
    .done         (done),
    .converged    (converged),
    .sweeps       (sweeps),
    .a_out        (a_out),
    .v_out        (v_out),
    .rot_valid    (rot_valid),
    .rot_i        (rot_i),
    .rot_j        (rot_j),
    .rot_diag     (rot_diag),
    .rot_q        (rot_q),
    .rot_done     (rot_done),
    .rot_diag_res (rot_diag_res),
    .rot_q_res    (rot_q_res)
  );

  task automatic check(input bit ok, input string name, input string detail);
    vectors++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: %s", name, detail);
    end
  endtask

  function automatic int mag(input elem_t x);
    int s;
    s = int'($signed(x));
    if (s < 0) s = -s;
    return (s > 32767) ? 32767 : s;
  endfunction

  function automatic mat_t ident();
    mat_t m;
    m = '0;
    for (int k = 0; k < N; k++) m[k][k] = elem_t'(1 << FRAC_BITS);
    return m;
  endfunction

  // Stand-in rotation engine: mode 0 halves the pivot pair toward zero, mode 1 returns inputs unchanged.
  function automatic void engine(input mat_t a, input mat_t v, input int i, input int j, input int mode,
                                 output mat_t ra, output mat_t rv);
    int x;
    ra = a;
    rv = v;
    if (mode == 0) begin
      x = int'($signed(a[i][j])) / 2;
      ra[i][j] = elem_t'(x);
      ra[j][i] = elem_t'(x);
      ra[i][i] = a[i][i] + elem_t'(3);
      rv[i][j] = v[i][j] + a[i][j];
    end
  endfunction

  function automatic mat_t rand_sym(input int lo, input int hi);
    mat_t m;
    int   x;
    for (int i = 0; i < N; i++)
      for (int j = i; j < N; j++) begin
        if (i == j) x = int'($urandom_range(0, 2000));
        else begin
          x = int'($urandom_range(lo, hi));
          if ($urandom % 2 == 1) x = -x;
        end
        m[i][j] = elem_t'(x);
        m[j][i] = elem_t'(x);
      end
    return m;
  endfunction

  // Reference sweep: cyclic pairs, optional skip, scan after each sweep, stop on TOL or sweep limit.
  task automatic model(input mat_t a0, input int mode, output int nreq, output bit first01);
    mat_t a, v, na, nv;
    int   sw, mx;
    bit   conv;
    req_t r;
    res_t d;
    a = a0; v = ident(); sw = 0; conv = 1'b0; nreq = 0; first01 = 1'b0;
    while (1) begin
      for (int i = 0; i < N - 1; i++)
        for (int j = i + 1; j < N; j++) begin
          if (SKIP && mag(a[i][j]) <= TOLV) continue;
          if (nreq == 0) first01 = (i == 0 && j == 1);
          r.i = i; r.j = j; r.a = a; r.v = v;
          req_q.push_back(r);
          nreq++;
          engine(a, v, i, j, mode, na, nv);
          a = na; v = nv;
        end
      sw++;
      mx = 0;
      for (int i = 0; i < N; i++)
        for (int j = 0; j < N; j++)
          if (i != j && mag(a[i][j]) > mx) mx = mag(a[i][j]);
      if (mx <= TOLV) begin conv = 1'b1; break; end
      if (sw == MAXS) break;
    end
    d.a = a; d.v = v; d.conv = conv; d.sw = sw;
    done_q.push_back(d);
  endtask

  // Engine responder: one outstanding request, fixed or random latency, optional stray pulse in CHECK.
  initial begin
    bit   pending;
    int   cnt, stray_cnt, ci, cj;
    mat_t cap_a, cap_v, res_a, res_v;
    rot_done = 1'b0; rot_diag_res = '0; rot_q_res = '0;
    pending = 1'b0; stray_cnt = 0; cnt = 0; ci = 0; cj = 0;
    forever begin
      @(negedge clk);
      rot_done = 1'b0;
      if (!rst_n) begin
        pending   = 1'b0;
        stray_cnt = 0;
      end else if (pending) begin
        check(!rot_valid, "one_outstanding", $sformatf("rot_valid=%0b while (%0d,%0d) pending, required 0", rot_valid, ci, cj));
        check(int'(rot_i) == ci && int'(rot_j) == cj && rot_diag == cap_a && rot_q == cap_v, "req_stable",
              $sformatf("pair now (%0d,%0d) required (%0d,%0d) or matrices changed", rot_i, rot_j, ci, cj));
        cnt--;
        if (cnt == 0) begin
          rot_done     = 1'b1;
          rot_diag_res = res_a;
          rot_q_res    = res_v;
          pending      = 1'b0;
          if (stray_en && ci == N - 2 && cj == N - 1) stray_cnt = 5;
        end
      end else if (stray_cnt > 0) begin
        stray_cnt--;
        if (stray_cnt == 0) begin
          rot_done     = 1'b1;
          rot_diag_res = rand_sym(0, 32767);
          rot_q_res    = rand_sym(0, 32767);
        end
      end else if (rot_valid) begin
        ci = int'(rot_i); cj = int'(rot_j); cap_a = rot_diag; cap_v = rot_q;
        engine(cap_a, cap_v, ci, cj, eng_mode, res_a, res_v);
        cnt     = (eng_lat > 0) ? eng_lat : int'($urandom_range(1, 6));
        pending = 1'b1;
        req_cnt++;
      end
    end
  end

  // Monitor: pops the scoreboard whenever the DUT issues a request or signals done.
  initial begin
    req_t e;
    res_t d;
    forever begin
      @(negedge clk);
      if (rst_n) begin
        if (rot_valid) begin
          if (req_q.size() == 0)
            check(1'b0, "unexpected_req", $sformatf("got pair (%0d,%0d), required none", rot_i, rot_j));
          else begin
            e = req_q.pop_front();
            check(int'(rot_i) == e.i && int'(rot_j) == e.j, "req_pair",
                  $sformatf("got (%0d,%0d) required (%0d,%0d)", rot_i, rot_j, e.i, e.j));
            check(rot_diag == e.a && rot_q == e.v, "req_matrix",
                  $sformatf("got diag %h q %h required diag %h q %h", rot_diag, rot_q, e.a, e.v));
          end
        end
        if (done) begin
          if (done_q.size() == 0)
            check(1'b0, "unexpected_done", "done pulsed, required none");
          else begin
            d = done_q.pop_front();
            check(a_out == d.a && v_out == d.v, "done_matrices",
                  $sformatf("got a %h v %h required a %h v %h", a_out, v_out, d.a, d.v));
            check(converged == d.conv && int'(sweeps) == d.sw, "done_status",
                  $sformatf("got conv=%0b sweeps=%0d required conv=%0b sweeps=%0d", converged, sweeps, d.conv, d.sw));
          end
        end
      end
    end
  end

  task automatic zero_check(input string name);
    check(!busy && !done && !converged && !rot_valid && rot_i == '0 && rot_j == '0 && sweeps == '0 &&
          a_out == '0 && v_out == '0 && rot_diag == '0 && rot_q == '0, name,
          $sformatf("busy=%0b done=%0b conv=%0b valid=%0b i=%0d j=%0d sweeps=%0d mats_nonzero=%0b, required all 0",
                    busy, done, converged, rot_valid, rot_i, rot_j, sweeps,
                    (a_out != '0) || (v_out != '0) || (rot_diag != '0) || (rot_q != '0)));
  endtask

  task automatic run(input mat_t a, input int mode, input int lat, input bit disturb, input int plan_nreq,
                     output mat_t ra, output mat_t rv);
    int nreq, cyc;
    bit f01;
    model(a, mode, nreq, f01);
    eng_mode = mode; eng_lat = lat; stray_en = disturb; req_cnt = 0;
    @(negedge clk);
    a_in = a; start = 1'b1;
    @(negedge clk);
    start = 1'b0; a_in = rand_sym(0, 32767);
    check(busy == 1'b1, "busy_t1", $sformatf("busy=%0b one cycle after start, required 1", busy));
    @(negedge clk);
    check(rot_valid == f01, "first_req_t2", $sformatf("rot_valid=%0b two cycles after start, required %0b", rot_valid, f01));
    if (disturb) begin
      repeat (4) @(negedge clk);
      start = 1'b1; a_in = rand_sym(0, 32767);
      @(negedge clk);
      start = 1'b0;
    end
    cyc = 0;
    while (!done && cyc < 20000) begin
      @(negedge clk);
      cyc++;
    end
    check(done == 1'b1, "done_timeout", $sformatf("done=%0b after %0d cycles, required 1", done, cyc));
    ra = a_out; rv = v_out;
    @(negedge clk);
    check(!done && !busy, "done_pulse", $sformatf("done=%0b busy=%0b after done cycle, required 0/0", done, busy));
    check(req_cnt == nreq, "req_count", $sformatf("got %0d requests, required %0d", req_cnt, nreq));
    if (plan_nreq >= 0)
      check(req_cnt == plan_nreq, "plan_req_count", $sformatf("got %0d requests, required %0d", req_cnt, plan_nreq));
    check(req_q.size() == 0 && done_q.size() == 0, "scoreboard_drained",
          $sformatf("%0d requests and %0d results left, required 0/0", req_q.size(), done_q.size()));
    req_q.delete(); done_q.delete();
    stray_en = 1'b0;
  endtask

  task automatic reset_test(input mat_t m);
    int nreq, cyc, seen;
    bit f01;
    model(m, 0, nreq, f01);
    eng_mode = 0; eng_lat = 12; stray_en = 1'b0;
    @(negedge clk);
    a_in = m; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 0;
    while (!(rot_valid && sweeps == 4'd1) && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    check(rot_valid && sweeps == 4'd1, "reach_sweep2", $sformatf("valid=%0b sweeps=%0d, required 1/1", rot_valid, sweeps));
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b0;
    #1 zero_check("reset_mid_wait");
    req_q.delete(); done_q.delete();
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (done) seen++;
    end
    check(seen == 0, "no_done_in_reset", $sformatf("done seen %0d times, required 0", seen));
    rst_n = 1'b1;
  endtask

  initial begin
    mat_t m, mr, ra1, rv1, ra2, rv2;
    rst_n = 1'b0; start = 1'b0; a_in = '0;
    eng_mode = 0; eng_lat = 1; stray_en = 1'b0; req_cnt = 0;
    repeat (3) @(negedge clk);
    zero_check("reset_values");
    rst_n = 1'b1;

    m = '0;
    for (int k = 0; k < N; k++) m[k][k] = elem_t'(100 * (k + 1));
    run(m, 0, 2, 1'b0, SKIP ? 0 : 6, ra1, rv1);

    for (int i = 0; i < N; i++)
      for (int j = 0; j < N; j++)
        if (i != j) m[i][j] = elem_t'(1000);
    run(m, 1, 1, 1'b0, 48, ra1, rv1);

    m = rand_sym(0, 32767);
    m[0][3] = 16'h8000; m[3][0] = 16'h8000;
    run(m, 0, 0, 1'b0, -1, ra1, rv1);
    run(rand_sym(0, 40), 0, 0, 1'b0, -1, ra1, rv1);
    run(rand_sym(0, 4000), 0, 0, 1'b0, -1, ra1, rv1);
    run(rand_sym(0, 32767), 0, 0, 1'b0, -1, ra1, rv1);

    m = rand_sym(300, 4000);
    run(m, 0, 1, 1'b0, -1, ra1, rv1);
    run(m, 0, 37, 1'b0, -1, ra2, rv2);
    check(ra1 == ra2 && rv1 == rv2, "latency_invariance", $sformatf("lat37 a %h v %h, lat1 a %h v %h", ra2, rv2, ra1, rv1));
    run(m, 0, 0, 1'b1, -1, ra2, rv2);
    check(ra1 == ra2 && rv1 == rv2, "disturb_invariance", $sformatf("disturbed a %h v %h, clean a %h v %h", ra2, rv2, ra1, rv1));

    mr = rand_sym(300, 4000);
    reset_test(mr);
    run(m, 0, 0, 1'b0, -1, ra2, rv2);
    check(ra1 == ra2 && rv1 == rv2, "post_reset_run", $sformatf("after reset a %h v %h, clean a %h v %h", ra2, rv2, ra1, rv1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
